// File: rtl/session_pkg.sv
// Shared types and constants for the session controller: FSM states, credential word
// layout and the fixed credential table.
package session_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StGranted,
    StFail,
    StLocked
  } state_e;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned ID_LSB  = 12;
  localparam int unsigned PIN_W   = 12;
  localparam int unsigned PIN_LSB = 0;

  localparam logic [PIN_W-1:0] PIN_USER1 = 12'h476;
  localparam logic [PIN_W-1:0] PIN_USER2 = 12'h9A3;
  localparam logic [PIN_W-1:0] PIN_USER3 = 12'h0C5;
  localparam logic [PIN_W-1:0] PIN_USER4 = 12'hF10;

  function automatic logic [PIN_W-1:0] cred_pin(input logic [ID_W-1:0] id);
    logic [PIN_W-1:0] pin;
    case (id)
      4'd1:    pin = PIN_USER1;
      4'd2:    pin = PIN_USER2;
      4'd3:    pin = PIN_USER3;
      4'd4:    pin = PIN_USER4;
      default: pin = '0;
    endcase
    return pin;
  endfunction

endpackage

// File: rtl/cred_rom.sv
// Combinational credential table: maps a user ID to its PIN and flags whether the ID
// names a real user.
module cred_rom
  import session_pkg::*;
#(
  parameter int unsigned NUM_USERS = 4
) (
  input  logic [ID_W-1:0]  id,
  output logic [PIN_W-1:0] pin,
  output logic             valid
);

  always_comb begin
    pin   = cred_pin(id);
    valid = (id != '0) && (id <= ID_W'(NUM_USERS));
  end

endmodule

// File: rtl/session_controller.sv
// Access-control FSM: credential check, session grant with logout, and lockout after
// repeated failures. Define SESSION_TIMEOUT_EN to build the idle-timeout logout.
module session_controller
  import session_pkg::*;
#(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned NUM_USERS      = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 64,
  parameter int unsigned IDLE_TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_load,
  input  logic              logout,
  input  logic              activity,
  output logic              access_grant,
  output logic [ID_W-1:0]   user_id,
  output logic              locked,
  output logic              auth_fail
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES);

  state_e              state_q, state_d;
  logic                load_q;
  logic [DATA_W-1:0]   cred_q;
  logic [ID_W-1:0]     user_q;
  logic [FAIL_W-1:0]   fail_q;
  logic [LOCK_W-1:0]   lock_q;
  logic [ID_W-1:0]     rom_id;
  logic [PIN_W-1:0]    rom_pin;
  logic                rom_valid;
  logic                cred_match;
  logic                load_edge;
  logic                lock_done;
  logic                timeout;

  assign load_edge  = data_in_load & ~load_q;
  assign rom_id     = cred_q[ID_LSB +: ID_W];
  assign cred_match = rom_valid && (cred_q[PIN_LSB +: PIN_W] == rom_pin);
  assign lock_done  = (lock_q == LOCK_W'(LOCKOUT_CYCLES - 1));

  cred_rom #(
    .NUM_USERS (NUM_USERS)
  ) u_cred_rom (
    .id    (rom_id),
    .pin   (rom_pin),
    .valid (rom_valid)
  );

`ifdef SESSION_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT);
  logic [IDLE_W-1:0] idle_q;

  // Activity in the final cycle still rescues the session.
  assign timeout = ~activity && (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q == StGranted && !activity) begin
      idle_q <= idle_q + 1'b1;
    end else begin
      idle_q <= '0;
    end
  end
`else
  logic unused_activity;
  assign unused_activity = activity;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (load_edge) state_d = StCheck;
      StCheck:   state_d = cred_match ? StGranted : StFail;
      StFail:    state_d = (fail_q == FAIL_W'(MAX_FAILS - 1)) ? StLocked : StIdle;
      StLocked:  if (lock_done) state_d = StIdle;
      StGranted: if (logout || timeout) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    access_grant = (state_q == StGranted);
    locked       = (state_q == StLocked);
    auth_fail    = (state_q == StFail);
    user_id      = user_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 1'b0;
      cred_q <= '0;
      user_q <= '0;
      fail_q <= '0;
      lock_q <= '0;
    end else begin
      load_q <= data_in_load;
      if (state_q == StIdle && load_edge) begin
        cred_q <= data_in;
      end
      // user_q is nonzero exactly while the session is granted.
      if (state_q == StCheck && cred_match) begin
        user_q <= rom_id;
      end else if (state_d != StGranted) begin
        user_q <= '0;
      end
      if ((state_q == StCheck && cred_match) || (state_q == StLocked && lock_done)) begin
        fail_q <= '0;
      end else if (state_q == StFail) begin
        fail_q <= fail_q + 1'b1;
      end
      lock_q <= (state_q == StLocked) ? lock_q + 1'b1 : '0;
    end
  end

endmodule
